// File: rtl/tiny45_alu_seq_if.sv
// rtl/tiny45_alu_seq_if.sv - request/result and nibble-ALU signal bundle for tiny45_alu_seq
interface tiny45_alu_seq_if;
    logic        start;
    logic        ready;
    logic [3:0]  op;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [31:0] result;
    logic        cmp_out;
    logic        result_valid;
    logic [3:0]  alu_op;
    logic [3:0]  alu_a;
    logic [3:0]  alu_b;
    logic        alu_cy_in;
    logic        alu_cmp_in;
    logic [3:0]  alu_d;
    logic        alu_cy_out;
    logic        alu_cmp_res;

    // Environment side: issues operations and provides the combinational ALU.
    modport master (
        output start, op, a_in, b_in, alu_d, alu_cy_out, alu_cmp_res,
        input  ready, result, cmp_out, result_valid,
        input  alu_op, alu_a, alu_b, alu_cy_in, alu_cmp_in
    );

    // Sequencer side.
    modport slave (
        input  start, op, a_in, b_in, alu_d, alu_cy_out, alu_cmp_res,
        output ready, result, cmp_out, result_valid,
        output alu_op, alu_a, alu_b, alu_cy_in, alu_cmp_in
    );
endinterface

// File: rtl/tiny45_alu_seq.sv
// rtl/tiny45_alu_seq.sv - nibble-serial operand sequencer around a 4-bit combinational ALU
module tiny45_alu_seq (
    input  logic                   clk,
    input  logic                   rstn,
    tiny45_alu_seq_if.slave        bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q;
    logic [2:0]  cnt_q;
    logic [3:0]  op_q;
    logic [31:0] a_sh_q;
    logic [31:0] b_sh_q;
    logic [31:0] res_sh_q;
    logic [31:0] res_sh_d;
    logic [31:0] result_q;
    logic        carry_q;
    logic        eq_q;
    logic        cmp_q;
    logic        valid_q;
    logic        run;

    assign run      = (state_q == RUN);
    assign res_sh_d = {bus.alu_d, res_sh_q[31:4]};

    assign bus.ready        = (state_q == IDLE);
    assign bus.result       = result_q;
    assign bus.cmp_out      = cmp_q;
    assign bus.result_valid = valid_q;
    assign bus.alu_op       = op_q;
    assign bus.alu_a        = run ? a_sh_q[3:0] : 4'd0;
    assign bus.alu_b        = run ? b_sh_q[3:0] : 4'd0;
    assign bus.alu_cy_in    = run ? carry_q : 1'b0;
    assign bus.alu_cmp_in   = run ? eq_q : 1'b0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            cnt_q    <= 3'd0;
            op_q     <= 4'd0;
            a_sh_q   <= 32'd0;
            b_sh_q   <= 32'd0;
            res_sh_q <= 32'd0;
            result_q <= 32'd0;
            carry_q  <= 1'b0;
            eq_q     <= 1'b0;
            cmp_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        op_q     <= bus.op;
                        a_sh_q   <= bus.a_in;
                        b_sh_q   <= bus.b_in;
                        cnt_q    <= 3'd0;
                        // Subtract-class ops need the +1 of the two's-complement of B.
                        carry_q  <= bus.op[1] | bus.op[3];
                        eq_q     <= 1'b1;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    a_sh_q   <= {4'd0, a_sh_q[31:4]};
                    b_sh_q   <= {4'd0, b_sh_q[31:4]};
                    res_sh_q <= res_sh_d;
                    carry_q  <= bus.alu_cy_out;
                    eq_q     <= bus.alu_cmp_res;
                    cnt_q    <= cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        cmp_q   <= bus.alu_cmp_res;
                        valid_q <= 1'b1;
                        state_q <= IDLE;
                        if (op_q[1:0] == 2'b01)
                            result_q <= 32'd0;
                        else if (op_q[2:1] == 2'b01)
                            result_q <= {31'd0, bus.alu_cmp_res};
                        else
                            result_q <= res_sh_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tiny45_alu_seq.sv
// tb/tb_tiny45_alu_seq.sv - scoreboard bench for tiny45_alu_seq with a behavioural nibble ALU
module tb_tiny45_alu_seq;
    localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB = 4'b1000, OP_SLT = 4'b0010,
                           OP_SLTU = 4'b0011, OP_AND = 4'b0111, OP_OR = 4'b0110,
                           OP_XOR = 4'b0100;

    typedef struct {
        logic [31:0] res;
        logic        cmp;
        bit          chk_cmp;
        int          acc_edge;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   edge_cnt = 0;
    int   checks = 0;
    int   errors = 0;
    int   n_exp = 0;
    int   n_valid = 0;
    exp_t sb[$];

    tiny45_alu_seq_if bus ();

    tiny45_alu_seq dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Behavioural 4-bit ALU: add/sub chain, signed/unsigned less-than on the top nibble, running equality.
    always_comb begin
        logic [3:0] bb;
        logic [4:0] s;
        logic       ovf;
        bb  = (bus.alu_op[3] | bus.alu_op[1]) ? ~bus.alu_b : bus.alu_b;
        s   = {1'b0, bus.alu_a} + {1'b0, bb} + {4'd0, bus.alu_cy_in};
        ovf = (bus.alu_a[3] == bb[3]) && (s[3] != bus.alu_a[3]);
        bus.alu_d       = 4'd0;
        bus.alu_cy_out  = 1'b0;
        bus.alu_cmp_res = 1'b0;
        case (bus.alu_op)
            OP_ADD, OP_SUB: begin bus.alu_d = s[3:0]; bus.alu_cy_out = s[4]; end
            OP_SLT:  begin bus.alu_d = s[3:0]; bus.alu_cy_out = s[4]; bus.alu_cmp_res = s[3] ^ ovf; end
            OP_SLTU: begin bus.alu_d = s[3:0]; bus.alu_cy_out = s[4]; bus.alu_cmp_res = ~s[4]; end
            OP_AND:  bus.alu_d = bus.alu_a & bus.alu_b;
            OP_OR:   bus.alu_d = bus.alu_a | bus.alu_b;
            OP_XOR:  begin
                bus.alu_d       = bus.alu_a ^ bus.alu_b;
                bus.alu_cmp_res = bus.alu_cmp_in & (bus.alu_a == bus.alu_b);
            end
            default: ;
        endcase
    end

    // Monitor: every result_valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rstn && bus.result_valid) begin
            exp_t e;
            n_valid++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid result=%h required no pulse", bus.result);
            end else begin
                e = sb.pop_front();
                if (bus.result !== e.res) begin
                    errors++;
                    $display("FAIL %s result got %h required %h", e.name, bus.result, e.res);
                end
                checks++;
                if (edge_cnt - e.acc_edge != 8) begin
                    errors++;
                    $display("FAIL %s latency got %0d required 8", e.name, edge_cnt - e.acc_edge);
                end
                if (e.chk_cmp) begin
                    checks++;
                    if (bus.cmp_out !== e.cmp) begin
                        errors++;
                        $display("FAIL %s cmp_out got %b required %b", e.name, bus.cmp_out, e.cmp);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got %h required %h", nm, got, req);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic ec, input bit cc,
                         input bit keep, input string nm);
        int   w;
        exp_t e;
        @(negedge clk);
        bus.op = op; bus.a_in = a; bus.b_in = b; bus.start = 1'b1;
        w = 0;
        while (!bus.ready && w < 20) begin @(negedge clk); w++; end
        if (!bus.ready) begin
            checks++; errors++;
            $display("FAIL %s accept_timeout ready=%b required 1", nm, bus.ready);
            bus.start = 1'b0;
            return;
        end
        @(posedge clk); #1;
        e.res = er; e.cmp = ec; e.chk_cmp = cc; e.acc_edge = edge_cnt; e.name = nm;
        sb.push_back(e);
        n_exp++;
        if (!keep) bus.start = 1'b0;
    endtask

    initial begin
        int w;
        bus.start = 1'b0; bus.op = 4'd0; bus.a_in = 32'd0; bus.b_in = 32'd0;
        #1;
        chk("reset_ready", {31'd0, bus.ready}, 32'd1);
        chk("reset_result", bus.result, 32'd0);
        chk("reset_valid", {31'd0, bus.result_valid}, 32'd0);
        chk("reset_cmp", {31'd0, bus.cmp_out}, 32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        issue(OP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 0, 0, "add_ovf");
        issue(OP_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 0, 0, "add_wrap");
        issue(OP_SUB,  32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 0, 0, "sub");
        issue(OP_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b1, 1, 0, "slt_neg");
        issue(OP_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1, 0, "sltu_big");
        issue(OP_SLT,  32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1, 0, "slt_pos");
        issue(OP_SLTU, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b1, 1, 0, "sltu_small");
        issue(OP_XOR,  32'hDEADBEEF, 32'hDEADBEEF, 32'h00000000, 1'b1, 1, 0, "eq_same");
        issue(OP_XOR,  32'hDEADBEEF, 32'hDEADBEEE, 32'h00000001, 1'b0, 1, 0, "eq_diff");

        // Logic op followed by start pulses while busy; none may be accepted.
        issue(OP_AND,  32'hF0F0F0F0, 32'h3C3C3C3C, 32'h30303030, 1'b0, 0, 0, "and");
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.start = ~bus.start;
            bus.op = OP_ADD; bus.a_in = 32'h11111111; bus.b_in = 32'h22222222;
        end
        @(negedge clk); bus.start = 1'b0;

        // Back-to-back with start held high across the three operations.
        issue(OP_OR,   32'hF0F0F0F0, 32'h3C3C3C3C, 32'hFCFCFCFC, 1'b0, 0, 1, "b2b_or");
        issue(OP_ADD,  32'h12345678, 32'h11111111, 32'h23456789, 1'b0, 0, 1, "b2b_add");
        issue(OP_SUB,  32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 0, 0, "b2b_sub");

        // Asynchronous reset in the middle of RUN aborts the operation silently.
        issue(OP_ADD,  32'h00000003, 32'h00000004, 32'h00000007, 1'b0, 0, 0, "aborted");
        repeat (4) @(posedge clk);
        #2;
        rstn = 1'b0;
        void'(sb.pop_back());
        n_exp--;
        #1;
        chk("midrun_reset_ready", {31'd0, bus.ready}, 32'd1);
        chk("midrun_reset_result", bus.result, 32'd0);
        chk("midrun_reset_valid", {31'd0, bus.result_valid}, 32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (12) @(negedge clk);

        issue(OP_ADD,  32'h00000003, 32'h00000004, 32'h00000007, 1'b0, 0, 0, "post_reset_add");

        w = 0;
        while (sb.size() != 0 && w < 50) begin @(negedge clk); w++; end
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout outstanding=%0d required 0", sb.size());
        end
        chk("valid_count", n_valid, n_exp);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
